// File: rtl/axi_timer.sv
// AXI4-Lite timer peripheral: 32-bit counter behind an 8-bit prescaler, compare register,
// sticky MATCH flag and a level interrupt. Registers decoded from address bits [3:2].
module axi_timer #(
    parameter int unsigned AXI_AWIDTH = 32,
    parameter int unsigned AXI_DWIDTH = 32
) (
    input  logic                  AXI_ACLK,
    input  logic                  AXI_ARESETN,
    input  logic [AXI_AWIDTH-1:0] AXI_AWADDR,
    input  logic                  AXI_AWVALID,
    output logic                  AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0] AXI_WDATA,
    input  logic [3:0]            AXI_WSTRB,
    input  logic                  AXI_WVALID,
    output logic                  AXI_WREADY,
    output logic [1:0]            AXI_BRESP,
    output logic                  AXI_BVALID,
    input  logic                  AXI_BREADY,
    input  logic [AXI_AWIDTH-1:0] AXI_ARADDR,
    input  logic                  AXI_ARVALID,
    output logic                  AXI_ARREADY,
    output logic [AXI_DWIDTH-1:0] AXI_RDATA,
    output logic [1:0]            AXI_RRESP,
    output logic                  AXI_RVALID,
    input  logic                  AXI_RREADY,
    output logic                  TIMER_IRQ
);

    localparam int unsigned DW  = AXI_DWIDTH;
    localparam int unsigned SW  = 4;
    localparam int unsigned PW  = 8;
    localparam int unsigned RAW = 2;

    localparam logic [RAW-1:0] REG_CTRL    = 2'd0;
    localparam logic [RAW-1:0] REG_STATUS  = 2'd1;
    localparam logic [RAW-1:0] REG_COUNT   = 2'd2;
    localparam logic [RAW-1:0] REG_COMPARE = 2'd3;

    typedef struct packed {
        logic [PW-1:0] prescale;
        logic          auto_reload;
        logic          irq_en;
        logic          en;
    } ctrl_t;

    // Write channel state
    logic           aw_pending_q, aw_pending_d;
    logic [RAW-1:0] waddr_q, waddr_d;
    logic           w_pending_q, w_pending_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]  wstrb_q, wstrb_d;
    logic           bvalid_q, bvalid_d;

    // Read channel state
    logic           rvalid_q, rvalid_d;
    logic [DW-1:0]  rdata_q, rdata_d;

    // Timer state
    ctrl_t          ctrl_q, ctrl_d;
    logic           match_q, match_d;
    logic [DW-1:0]  count_q, count_d;
    logic [DW-1:0]  compare_q, compare_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           irq_q, irq_d;

    logic           aw_hs, w_hs, ar_hs, commit;
    logic           wr_ctrl, wr_status, wr_count, wr_compare;
    logic           tick, hit, match_set, match_clr;
    logic [DW-1:0]  rd_word;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{AXI_AWADDR[AXI_AWIDTH-1:4], AXI_AWADDR[1:0],
                                AXI_ARADDR[AXI_AWIDTH-1:4], AXI_ARADDR[1:0]};

    function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < int'(SW); b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    assign AXI_AWREADY = !aw_pending_q && !bvalid_q;
    assign AXI_WREADY  = !w_pending_q && !bvalid_q;
    assign AXI_ARREADY = !rvalid_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_BRESP   = 2'b00;
    assign AXI_RVALID  = rvalid_q;
    assign AXI_RDATA   = rdata_q;
    assign AXI_RRESP   = 2'b00;
    assign TIMER_IRQ   = irq_q;

    assign aw_hs  = AXI_AWVALID && AXI_AWREADY;
    assign w_hs   = AXI_WVALID && AXI_WREADY;
    assign ar_hs  = AXI_ARVALID && AXI_ARREADY;
    assign commit = aw_pending_q && w_pending_q;

    assign wr_ctrl    = commit && (waddr_q == REG_CTRL);
    assign wr_status  = commit && (waddr_q == REG_STATUS);
    assign wr_count   = commit && (waddr_q == REG_COUNT);
    assign wr_compare = commit && (waddr_q == REG_COMPARE);

    assign tick      = ctrl_q.en && (presc_q == ctrl_q.prescale);
    assign hit       = (count_q == compare_q);
    assign match_set = tick && hit;
    assign match_clr = wr_status && wstrb_q[0] && wdata_q[0];

    // Register readback; unimplemented bits read as zero
    always_comb begin
        rd_word = '0;
        unique case (AXI_ARADDR[3:2])
            REG_CTRL: begin
                rd_word[15:8] = ctrl_q.prescale;
                rd_word[2:0]  = {ctrl_q.auto_reload, ctrl_q.irq_en, ctrl_q.en};
            end
            REG_STATUS:  rd_word[0] = match_q;
            REG_COUNT:   rd_word = count_q;
            REG_COMPARE: rd_word = compare_q;
            default:     rd_word = '0;
        endcase
    end

    // Bus channel next state
    always_comb begin
        aw_pending_d = aw_pending_q;
        waddr_d      = waddr_q;
        w_pending_d  = w_pending_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;

        if (aw_hs) begin
            aw_pending_d = 1'b1;
            waddr_d      = AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_pending_d = 1'b1;
            wdata_d     = AXI_WDATA;
            wstrb_d     = AXI_WSTRB;
        end
        if (bvalid_q && AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_pending_d = 1'b0;
            w_pending_d  = 1'b0;
            bvalid_d     = 1'b1;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end else if (rvalid_q && AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // Timer next state; software COUNT write beats a tick, MATCH set beats a W1C clear
    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        presc_d   = presc_q;
        match_d   = match_set || (match_q && !match_clr);

        if (wr_ctrl) begin
            if (wstrb_q[0]) begin
                ctrl_d.en          = wdata_q[0];
                ctrl_d.irq_en      = wdata_q[1];
                ctrl_d.auto_reload = wdata_q[2];
            end
            if (wstrb_q[1]) ctrl_d.prescale = wdata_q[15:8];
        end

        if (wr_compare) compare_d = merge_strb(compare_q, wdata_q, wstrb_q);

        if (!ctrl_q.en || tick || wr_count) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (wr_count) begin
            count_d = merge_strb(count_q, wdata_q, wstrb_q);
        end else if (tick) begin
            count_d = (hit && ctrl_q.auto_reload) ? '0 : count_q + DW'(1);
        end

        irq_d = match_d && ctrl_d.irq_en;
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            aw_pending_q <= 1'b0;
            waddr_q      <= '0;
            w_pending_q  <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            ctrl_q       <= '0;
            match_q      <= 1'b0;
            count_q      <= '0;
            compare_q    <= '1;
            presc_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            aw_pending_q <= aw_pending_d;
            waddr_q      <= waddr_d;
            w_pending_q  <= w_pending_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            ctrl_q       <= ctrl_d;
            match_q      <= match_d;
            count_q      <= count_d;
            compare_q    <= compare_d;
            presc_q      <= presc_d;
            irq_q        <= irq_d;
        end
    end

endmodule

// File: tb/tb_axi_timer.sv
// Directed bench for axi_timer: read expectations queued at issue, checked when RVALID arrives.
module tb_axi_timer;

    localparam logic [31:0] A_CTRL = 32'h5000_0000;
    localparam logic [31:0] A_STAT = 32'h5000_0004;
    localparam logic [31:0] A_CNT  = 32'h5000_0008;
    localparam logic [31:0] A_CMP  = 32'h5000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    axi_timer #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
        .AXI_ACLK    (clk),
        .AXI_ARESETN (rst_n),
        .AXI_AWADDR  (awaddr),
        .AXI_AWVALID (awvalid),
        .AXI_AWREADY (awready),
        .AXI_WDATA   (wdata),
        .AXI_WSTRB   (wstrb),
        .AXI_WVALID  (wvalid),
        .AXI_WREADY  (wready),
        .AXI_BRESP   (bresp),
        .AXI_BVALID  (bvalid),
        .AXI_BREADY  (bready),
        .AXI_ARADDR  (araddr),
        .AXI_ARVALID (arvalid),
        .AXI_ARREADY (arready),
        .AXI_RDATA   (rdata),
        .AXI_RRESP   (rresp),
        .AXI_RVALID  (rvalid),
        .AXI_RREADY  (rready),
        .TIMER_IRQ   (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] data);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Full write; returns the edge index at which the commit happened
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output int unsigned commit_cyc);
        bit aw_done, w_done, awr, wr;
        int n;
        int unsigned start;
        start   = cyc;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            awr = awready;
            wr  = wready;
            tick1();
            if (awvalid && awr) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (wvalid && wr)   begin w_done  = 1'b1; wvalid  = 1'b0; end
            n++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin
            tick1();
            n++;
        end
        check1("b_wait", bvalid, 1'b1);
        commit_cyc = cyc;
        check("w_commit_latency", commit_cyc, start + 2);
        tick1();
    endtask

    task automatic read_issue(input logic [31:0] addr, output int unsigned hs_cyc);
        bit arr, done;
        int n;
        araddr  = addr;
        arvalid = 1'b1;
        done    = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            arr = arready;
            tick1();
            if (arr) done = 1'b1;
            n++;
        end
        arvalid = 1'b0;
        hs_cyc  = cyc;
    endtask

    task automatic read_collect();
        exp_t e;
        int n;
        n = 0;
        while (rvalid !== 1'b1 && n < 20) begin
            tick1();
            n++;
        end
        check1("r_wait", rvalid, 1'b1);
        e = exp_q.pop_front();
        check(e.tag, rdata, e.data);
        rready = 1'b1;
        tick1();
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        int unsigned hs;
        expect_rd(tag, exp);
        read_issue(addr, hs);
        read_collect();
    endtask

    initial begin
        int unsigned c, c2, hs;

        // Outputs while reset is held
        tick1();
        tick1();
        check1("rst_awready", awready, 1'b1);
        check1("rst_wready", wready, 1'b1);
        check1("rst_arready", arready, 1'b1);
        check1("rst_bvalid", bvalid, 1'b0);
        check1("rst_rvalid", rvalid, 1'b0);
        check1("rst_irq", irq, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", 32'({bresp, rresp}), 32'h0);
        rst_n = 1'b1;
        tick1();

        axi_read(A_CNT,  32'h0000_0000, "rst_count");
        axi_read(A_CMP,  32'hFFFF_FFFF, "rst_compare");
        axi_read(A_CTRL, 32'h0000_0000, "rst_ctrl");
        axi_read(A_STAT, 32'h0000_0000, "rst_status");

        // Prescaled count: PRESCALE=4 -> one increment every 5 cycles
        axi_write(A_CNT, 32'h0, 4'hF, c);
        axi_write(A_CTRL, 32'h0000_0401, 4'hF, c);
        axi_read(A_CTRL, 32'h0000_0401, "ctrl_readback");
        while (cyc < c + 49) tick1();
        expect_rd("presc_50", 32'(((c + 49) - c) / 5));
        read_issue(A_CNT, hs);
        check1("presc_50_range", (rdata >= 32'd9) && (rdata <= 32'd11), 1'b1);
        read_collect();
        for (int i = 0; i < 6; i++) begin
            repeat (i % 3) tick1();
            read_issue(A_CNT, hs);
            expect_rd("presc_phase", 32'((hs - 1 - c) / 5));
            read_collect();
        end
        axi_write(A_CTRL, 32'h0, 4'hF, c);

        // Match with auto-reload, one tick per cycle
        axi_write(A_CNT, 32'h0, 4'hF, c);
        axi_write(A_CMP, 32'd3, 4'hF, c);
        axi_write(A_CTRL, 32'h0000_0007, 4'hF, c);
        for (int i = 0; i < 6; i++) begin
            check1("irq_rise", irq, (cyc - c) >= 4);
            tick1();
        end
        for (int i = 0; i < 4; i++) begin
            read_issue(A_CNT, hs);
            expect_rd("reload_seq", 32'((hs - 1 - c) % 4));
            read_collect();
        end
        axi_write(A_CTRL, 32'h0000_0006, 4'hF, c);
        check1("irq_hold_disabled", irq, 1'b1);
        axi_read(A_STAT, 32'h1, "status_match");
        axi_write(A_STAT, 32'h1, 4'hE, c);
        check1("w1c_no_strb", irq, 1'b1);
        axi_write(A_STAT, 32'h1, 4'h1, c);
        check1("w1c_clear_irq", irq, 1'b0);
        axi_read(A_STAT, 32'h0, "status_cleared");

        // W1C landing on the match tick: set wins
        axi_write(A_CNT, 32'h0, 4'hF, c);
        axi_write(A_CMP, 32'd10, 4'hF, c);
        axi_write(A_CTRL, 32'h0000_0003, 4'hF, c);
        while (cyc < c + 9) tick1();
        axi_write(A_STAT, 32'h1, 4'h1, c2);
        check("w1c_on_tick_edge", c2 - c, 32'd11);
        check1("w1c_collide_irq", irq, 1'b1);
        axi_read(A_STAT, 32'h1, "w1c_collide_status");
        axi_write(A_STAT, 32'h1, 4'h1, c2);
        check1("w1c_after_irq", irq, 1'b0);
        axi_write(A_CTRL, 32'h0, 4'hF, c);

        // COUNT write landing on a tick: written value wins
        axi_write(A_CTRL, 32'h0000_0301, 4'hF, c);
        while (((cyc + 2 - c) % 4) != 0) tick1();
        axi_write(A_CNT, 32'h0000_1234, 4'hF, c2);
        check("cntwr_tick_phase", (c2 - c) % 4, 32'd0);
        for (int i = 0; i < 3; i++) begin
            read_issue(A_CNT, hs);
            expect_rd("cntwr_collide", 32'h0000_1234 + 32'((hs - 1 - c2) / 4));
            read_collect();
        end
        axi_write(A_CTRL, 32'h0, 4'hF, c);

        // Wrap 0xFFFFFFFF -> 0 without a match
        axi_write(A_CMP, 32'd5, 4'hF, c);
        axi_write(A_CNT, 32'hFFFF_FFFF, 4'hF, c);
        axi_write(A_CTRL, 32'h0000_1001, 4'hF, c);
        while (cyc < c + 20) tick1();
        axi_read(A_CNT, 32'h0, "wrap_count");
        axi_read(A_STAT, 32'h0, "wrap_no_match");
        axi_write(A_CTRL, 32'h0, 4'hF, c);

        // Byte strobes
        axi_write(A_CNT, 32'h1122_3344, 4'hF, c);
        axi_write(A_CNT, 32'hAABB_CCDD, 4'b0010, c);
        axi_read(A_CNT, 32'h1122_CC44, "strb_count_byte1");
        axi_write(A_CTRL, 32'hFFFF_FFFF, 4'b0010, c);
        axi_read(A_CTRL, 32'h0000_FF00, "strb_ctrl_byte1");
        axi_write(A_CTRL, 32'h0, 4'hF, c);

        // W three cycles ahead of AW, then B backpressure
        bready = 1'b0;
        wdata  = 32'h55;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        tick1();
        wvalid = 1'b0;
        check1("w_only_wready", wready, 1'b0);
        check1("w_only_awready", awready, 1'b1);
        tick1();
        tick1();
        check1("w_only_no_b", bvalid, 1'b0);
        awaddr  = A_CMP;
        awvalid = 1'b1;
        tick1();
        awvalid = 1'b0;
        check1("aw_edge_bvalid", bvalid, 1'b0);
        tick1();
        check1("aw_plus1_bvalid", bvalid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check1("bp_bvalid", bvalid, 1'b1);
            check("bp_bresp", 32'(bresp), 32'h0);
            check1("bp_awready", awready, 1'b0);
            tick1();
        end
        bready = 1'b1;
        tick1();
        check1("bp_release", bvalid, 1'b0);
        axi_read(A_CMP, 32'h55, "order_compare");

        // R backpressure: data held even while the register changes underneath
        rready = 1'b0;
        expect_rd("rbp_data", 32'h55);
        read_issue(A_CMP, hs);
        check("rbp_rdata_0", rdata, 32'h55);
        axi_write(A_CMP, 32'h66, 4'hF, c);
        for (int i = 0; i < 3; i++) begin
            check1("rbp_rvalid", rvalid, 1'b1);
            check("rbp_rdata", rdata, 32'h55);
            check1("rbp_arready", arready, 1'b0);
            tick1();
        end
        read_collect();
        axi_read(A_CMP, 32'h66, "rbp_after");

        // Reset with an address pending: no partial write survives
        awaddr  = A_CMP;
        awvalid = 1'b1;
        tick1();
        awvalid = 1'b0;
        check1("pend_awready", awready, 1'b0);
        rst_n = 1'b0;
        #1;
        check1("midrst_awready", awready, 1'b1);
        tick1();
        rst_n = 1'b1;
        wdata  = 32'h77;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        tick1();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("midrst_no_commit", bvalid, 1'b0);
            tick1();
        end
        axi_read(A_CMP, 32'hFFFF_FFFF, "midrst_compare");
        awaddr  = A_CMP;
        awvalid = 1'b1;
        tick1();
        awvalid = 1'b0;
        tick1();
        check1("midrst_late_b", bvalid, 1'b1);
        tick1();
        axi_read(A_CMP, 32'h77, "midrst_late_write");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
